seg_display_arbiter: RTL and testbench

- Shares one 4-digit seven-segment display between two requesters: client 0 (normal status, low priority) and client 1 (alert/message, high priority).
- Drives the four digit nibbles and a blank flag that feed the existing multiplexed seven-segment driver.
- Enforces a minimum dwell time per owner so the display never flickers between sources.
- Enforces a maximum alert hold so client 0 cannot be starved.

---
 rtl/seg_display_arbiter.sv | 125 ++++++++++++
 tb/tb_seg_display_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_arbiter.sv
// Two-client arbiter for a shared 4-digit seven-segment display, with minimum dwell and maximum alert hold.
// Optional SEG_ALERT_BLINK_EN: flashes the display while the alert client (client 1) owns it.
module seg_display_arbiter #(
    parameter int TIMER_W   = 24,
    parameter int MIN_HOLD  = 1000000,
    parameter int MAX_HOLD  = 10000000,
    parameter int BLINK_BIT = 23
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req0,
    input  logic [15:0] data0,
    input  logic        req1,
    input  logic [15:0] data1,
    output logic        gnt0,
    output logic        gnt1,
    output logic [3:0]  dig_a,
    output logic [3:0]  dig_b,
    output logic [3:0]  dig_c,
    output logic [3:0]  dig_d,
    output logic        disp_blank
);

    // state | meaning
    // IDLE  | nobody owns the display, blanked
    // G0    | client 0 (status) owns the display
    // G1    | client 1 (alert) owns the display
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] G0   = 2'd1;
    localparam logic [1:0] G1   = 2'd2;

    localparam logic [TIMER_W-1:0] MIN_M1 = TIMER_W'(MIN_HOLD - 1);
    localparam logic [TIMER_W-1:0] MAX_M1 = TIMER_W'(MAX_HOLD - 1);

    if (MIN_HOLD < 1 || MAX_HOLD < MIN_HOLD || BLINK_BIT < 0) begin : g_param_check
        $error("seg_display_arbiter: illegal hold/blink parameters");
    end

    logic [1:0]         state_q, state_d;
    logic [TIMER_W-1:0] dwell_q, dwell_d;
    logic [15:0]        digits_q, digits_d;
    logic               blank_q, blank_d;
    logic               dwell_done;

    assign dwell_done = (dwell_q >= MIN_M1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req1)      state_d = G1;
                else if (req0) state_d = G0;
            end
            G0: begin
                if (dwell_done && req1)       state_d = G1;
                else if (dwell_done && !req0) state_d = IDLE;
            end
            G1: begin
                // fairness: a long alert yields to a waiting status client
                if (req1 && req0 && dwell_q >= MAX_M1) state_d = G0;
                else if (dwell_done && !req1)          state_d = req0 ? G0 : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        if (state_d != state_q)  dwell_d = '0;
        else if (dwell_q == '1)  dwell_d = dwell_q;
        else                     dwell_d = dwell_q + 1'b1;
    end

    always_comb begin
        case (state_d)
            G0:      digits_d = data0;
            G1:      digits_d = data1;
            default: digits_d = (state_q != IDLE) ? 16'h0000 : digits_q;
        endcase
    end

`ifdef SEG_ALERT_BLINK_EN
    logic [BLINK_BIT:0] blink_q, blink_d;

    // restarting on entry makes the first phase of every alert visible
    assign blink_d = (state_d == G1 && state_q != G1) ? '0 : blink_q + 1'b1;

    always_comb begin
        case (state_d)
            IDLE:    blank_d = 1'b1;
            G1:      blank_d = blink_d[BLINK_BIT];
            default: blank_d = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) blink_q <= '0;
        else          blink_q <= blink_d;
    end
`else
    assign blank_d = (state_d == IDLE);
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            dwell_q  <= '0;
            digits_q <= 16'h0000;
            blank_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            dwell_q  <= dwell_d;
            digits_q <= digits_d;
            blank_q  <= blank_d;
        end
    end

    assign gnt0       = (state_q == G0);
    assign gnt1       = (state_q == G1);
    assign dig_a      = digits_q[3:0];
    assign dig_b      = digits_q[7:4];
    assign dig_c      = digits_q[11:8];
    assign dig_d      = digits_q[15:12];
    assign disp_blank = blank_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Scoreboard bench for seg_display_arbiter with short hold times; follows SEG_ALERT_BLINK_EN if defined.
module tb_seg_display_arbiter;

    localparam int TIMER_W   = 8;
    localparam int MIN_HOLD  = 4;
    localparam int MAX_HOLD  = 16;
    localparam int BLINK_BIT = 2;
`ifdef SEG_ALERT_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req0, req1;
    logic [15:0] data0, data1;
    logic        gnt0, gnt1;
    logic [3:0]  dig_a, dig_b, dig_c, dig_d;
    logic        disp_blank;

    seg_display_arbiter #(
        .TIMER_W(TIMER_W), .MIN_HOLD(MIN_HOLD), .MAX_HOLD(MAX_HOLD), .BLINK_BIT(BLINK_BIT)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .req0(req0), .data0(data0), .req1(req1), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1),
        .dig_a(dig_a), .dig_b(dig_b), .dig_c(dig_c), .dig_d(dig_d),
        .disp_blank(disp_blank)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        gnt0;
        logic        gnt1;
        logic [15:0] digs;
        logic        blank;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // reference model: state, cycles spent in it (1 on entry), blink phase
    int m_state;
    int m_age;
    int m_blink;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] shown();
        return {dig_d, dig_c, dig_b, dig_a};
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_age   = 1;
        m_blink = 0;
    endtask

    task automatic step(input logic r0, input logic [15:0] d0, input logic r1, input logic [15:0] d1);
        int   ns;
        exp_t e;
        req0 = r0; data0 = d0; req1 = r1; data1 = d1;
        ns = m_state;
        case (m_state)
            0: ns = r1 ? 2 : (r0 ? 1 : 0);
            1: begin
                if (m_age >= MIN_HOLD && r1)       ns = 2;
                else if (m_age >= MIN_HOLD && !r0) ns = 0;
            end
            default: begin
                if (r1 && r0 && m_age >= MAX_HOLD) ns = 1;
                else if (m_age >= MIN_HOLD && !r1) ns = r0 ? 1 : 0;
            end
        endcase
        if (ns != m_state) begin
            m_age = 1;
            m_blink = (ns == 2) ? 0 : (m_blink + 1) % 8;
        end else begin
            if (m_age < 256) m_age++;
            m_blink = (m_blink + 1) % 8;
        end
        e.gnt0  = (ns == 1);
        e.gnt1  = (ns == 2);
        e.digs  = (ns == 1) ? d0 : ((ns == 2) ? d1 : 16'h0000);
        e.blank = (ns == 0) ? 1'b1 : ((ns == 2 && BLINK) ? (m_blink >= 4) : 1'b0);
        m_state = ns;
        sb.push_back(e);

        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("gnt0",  {31'd0, gnt0}, {31'd0, e.gnt0});
            chk("gnt1",  {31'd0, gnt1}, {31'd0, e.gnt1});
            chk("digs",  {16'd0, shown()}, {16'd0, e.digs});
            chk("blank", {31'd0, disp_blank}, {31'd0, e.blank});
            if (gnt0 && gnt1) chk("both_gnt", 32'd1, 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] pat;
        reset_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; data0 = 16'h0; data1 = 16'h0;
        model_reset();
        @(posedge clock);
        #1;
        chk("rst_gnt0",  {31'd0, gnt0}, 32'd0);
        chk("rst_gnt1",  {31'd0, gnt1}, 32'd0);
        chk("rst_digs",  {16'd0, shown()}, 32'd0);
        chk("rst_blank", {31'd0, disp_blank}, 32'd1);
        #3 reset_n = 1'b1;

        repeat (6) step(1'b0, 16'h0, 1'b0, 16'h0);

        step(1'b1, 16'h1234, 1'b0, 16'h0);
        chk("g0_entry_digs", {16'd0, shown()}, 32'h1234);
        chk("g0_entry_blank", {31'd0, disp_blank}, 32'd0);
        step(1'b1, 16'h5678, 1'b0, 16'h0);
        chk("g0_live_digs", {16'd0, shown()}, 32'h5678);

        step(1'b1, 16'h5678, 1'b1, 16'hABCD);
        chk("g0_hold3", {31'd0, gnt0}, 32'd1);
        step(1'b1, 16'h5678, 1'b1, 16'hABCD);
        chk("g0_hold4", {31'd0, gnt0}, 32'd1);
        step(1'b1, 16'h5678, 1'b1, 16'hABCD);
        chk("preempt_gnt1", {31'd0, gnt1}, 32'd1);
        chk("preempt_digs", {16'd0, shown()}, 32'hABCD);

        n = 1;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 16'h5678, 1'b1, 16'hABCD);
            if (gnt1) n++;
            else break;
        end
        chk("fair_len", n, 32'd16);
        chk("fair_gnt0", {31'd0, gnt0}, 32'd1);

        n = 1;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 16'h5678, 1'b1, 16'hABCD);
            if (gnt0) n++;
            else break;
        end
        chk("g0_guard_len", n, 32'd4);
        chk("g1_regain", {31'd0, gnt1}, 32'd1);

        repeat (3) step(1'b0, 16'h0, 1'b1, 16'hABCD);
        step(1'b0, 16'h0, 1'b0, 16'h0);
        chk("g1_release_blank", {31'd0, disp_blank}, 32'd1);

        step(1'b1, 16'h9999, 1'b0, 16'h0);
        n = 1;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 16'h0, 1'b0, 16'h0);
            if (gnt0) n++;
            else break;
        end
        chk("pulse_len", n, 32'd4);
        chk("pulse_idle_blank", {31'd0, disp_blank}, 32'd1);
        chk("pulse_idle_digs", {16'd0, shown()}, 32'd0);

        pat = 8'h00;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 16'h0, 1'b1, 16'h4321);
            pat[i] = disp_blank;
        end
        chk("blink_pat", {24'd0, pat}, BLINK ? 32'h0000_00F0 : 32'd0);

        #3 reset_n = 1'b0;
        #1;
        chk("async_gnt1",  {31'd0, gnt1}, 32'd0);
        chk("async_gnt0",  {31'd0, gnt0}, 32'd0);
        chk("async_digs",  {16'd0, shown()}, 32'd0);
        chk("async_blank", {31'd0, disp_blank}, 32'd1);
        model_reset();
        #3 reset_n = 1'b1;

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 2) != 0), 16'($urandom), ($urandom_range(0, 2) == 0), 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
